// File: rtl/axi_reg_slice_pkg.sv
// Shared widths, payload structs and burst encodings for the AXI register slice.
package axi_reg_slice_pkg;
  localparam int ID_W_WIDTH  = 4;
  localparam int ID_R_WIDTH  = 4;
  localparam int ADDR_WIDTH  = 16;
  localparam int DATA_WIDTH  = 32;
  localparam int BYTE_WIDTH  = 8;
  localparam int BATCH_WIDTH = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef struct packed {
    logic [ID_W_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_pld_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [BATCH_WIDTH-1:0] strb;
    logic                   last;
  } w_pld_t;

  typedef struct packed {
    logic [ID_W_WIDTH-1:0] id;
  } b_pld_t;

  typedef struct packed {
    logic [ID_R_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_pld_t;

  typedef struct packed {
    logic [ID_R_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } r_pld_t;
endpackage

// File: rtl/axi_reg_slice_if.sv
// Reduced AXI bundle (only the fields the RAM bridge consumes); s faces the master, m faces the RAM.
interface axi_if;
  import axi_reg_slice_pkg::*;

  logic                   awvalid, awready;
  logic [ID_W_WIDTH-1:0]  awid;
  logic [ADDR_WIDTH-1:0]  awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;

  logic                   wvalid, wready;
  logic [DATA_WIDTH-1:0]  wdata;
  logic [BATCH_WIDTH-1:0] wstrb;
  logic                   wlast;

  logic                   bvalid, bready;
  logic [ID_W_WIDTH-1:0]  bid;

  logic                   arvalid, arready;
  logic [ID_R_WIDTH-1:0]  arid;
  logic [ADDR_WIDTH-1:0]  araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;

  logic                   rvalid, rready;
  logic [ID_R_WIDTH-1:0]  rid;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   rlast;

  modport s (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bid, arready, rvalid, rid, rdata, rlast
  );

  modport m (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bid, arready, rvalid, rid, rdata, rlast
  );
endinterface

// File: rtl/axi_reg_slice_skid.sv
// Two-entry skid cell: every output is a flop, so no comb path crosses it in either direction.
module axi_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             accept, load_main;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid && !skid_valid;
  // main is free this cycle if empty or being consumed
  assign load_main = !main_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (load_main) begin
      if (skid_valid) begin
        // skid holds the older beat; accept is impossible here
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_data <= in_data;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/axi_reg_slice.sv
// AXI register slice: one independent skid cell per channel, AW/W/AR forward, B/R reverse.
module axi_reg_slice
  import axi_reg_slice_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  axi_if.s     axi_s,
  axi_if.m     axi_m
);
  aw_pld_t aw_in, aw_out;
  w_pld_t  w_in,  w_out;
  b_pld_t  b_in,  b_out;
  ar_pld_t ar_in, ar_out;
  r_pld_t  r_in,  r_out;

  assign aw_in = '{id: axi_s.awid, addr: axi_s.awaddr, len: axi_s.awlen,
                   size: axi_s.awsize, burst: axi_s.awburst};
  assign w_in  = '{data: axi_s.wdata, strb: axi_s.wstrb, last: axi_s.wlast};
  assign ar_in = '{id: axi_s.arid, addr: axi_s.araddr, len: axi_s.arlen,
                   size: axi_s.arsize, burst: axi_s.arburst};
  assign b_in  = '{id: axi_m.bid};
  assign r_in  = '{id: axi_m.rid, data: axi_m.rdata, last: axi_m.rlast};

  axi_skid_buffer #(.WIDTH($bits(aw_pld_t))) u_aw (
    .clk, .rst_n,
    .in_valid (axi_s.awvalid), .in_ready (axi_s.awready), .in_data (aw_in),
    .out_valid(axi_m.awvalid), .out_ready(axi_m.awready), .out_data(aw_out)
  );

  axi_skid_buffer #(.WIDTH($bits(w_pld_t))) u_w (
    .clk, .rst_n,
    .in_valid (axi_s.wvalid), .in_ready (axi_s.wready), .in_data (w_in),
    .out_valid(axi_m.wvalid), .out_ready(axi_m.wready), .out_data(w_out)
  );

  axi_skid_buffer #(.WIDTH($bits(ar_pld_t))) u_ar (
    .clk, .rst_n,
    .in_valid (axi_s.arvalid), .in_ready (axi_s.arready), .in_data (ar_in),
    .out_valid(axi_m.arvalid), .out_ready(axi_m.arready), .out_data(ar_out)
  );

  axi_skid_buffer #(.WIDTH($bits(b_pld_t))) u_b (
    .clk, .rst_n,
    .in_valid (axi_m.bvalid), .in_ready (axi_m.bready), .in_data (b_in),
    .out_valid(axi_s.bvalid), .out_ready(axi_s.bready), .out_data(b_out)
  );

  axi_skid_buffer #(.WIDTH($bits(r_pld_t))) u_r (
    .clk, .rst_n,
    .in_valid (axi_m.rvalid), .in_ready (axi_m.rready), .in_data (r_in),
    .out_valid(axi_s.rvalid), .out_ready(axi_s.rready), .out_data(r_out)
  );

  assign axi_m.awid    = aw_out.id;
  assign axi_m.awaddr  = aw_out.addr;
  assign axi_m.awlen   = aw_out.len;
  assign axi_m.awsize  = aw_out.size;
  assign axi_m.awburst = aw_out.burst;

  assign axi_m.wdata   = w_out.data;
  assign axi_m.wstrb   = w_out.strb;
  assign axi_m.wlast   = w_out.last;

  assign axi_m.arid    = ar_out.id;
  assign axi_m.araddr  = ar_out.addr;
  assign axi_m.arlen   = ar_out.len;
  assign axi_m.arsize  = ar_out.size;
  assign axi_m.arburst = ar_out.burst;

  assign axi_s.bid     = b_out.id;

  assign axi_s.rid     = r_out.id;
  assign axi_s.rdata   = r_out.data;
  assign axi_s.rlast   = r_out.last;
endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: each channel modelled as an ordered queue of at most two in-flight beats.
module tb_axi_reg_slice;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axi_if s_if();
  axi_if m_if();

  axi_reg_slice dut (.clk(clk), .rst_n(rst_n), .axi_s(s_if), .axi_m(m_if));

  // channel index: 0 AW, 1 W, 2 AR (forward), 3 B, 4 R (reverse)
  logic        drv_v [5];
  logic        drv_r [5];
  logic [63:0] drv_d [5];
  logic        ob_ir [5];
  logic        ob_ov [5];
  logic [63:0] ob_od [5];

  logic [63:0] mq  [5][$];
  logic [63:0] src [5][$];
  int vp [5];
  int rp [5];
  int nout [5];
  int nlast [5];
  int first_in [5];
  int first_out [5];
  int last_out [5];
  int cyc = 0;
  int vectors = 0;
  int fails = 0;
  string cn [5] = '{"aw", "w", "ar", "b", "r"};
  int wid [5] = '{33, 37, 33, 4, 37};

  assign s_if.awvalid = drv_v[0];
  assign {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst} = drv_d[0][32:0];
  assign m_if.awready = drv_r[0];
  assign ob_ir[0] = s_if.awready;
  assign ob_ov[0] = m_if.awvalid;
  assign ob_od[0] = {31'd0, m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst};

  assign s_if.wvalid = drv_v[1];
  assign {s_if.wdata, s_if.wstrb, s_if.wlast} = drv_d[1][36:0];
  assign m_if.wready = drv_r[1];
  assign ob_ir[1] = s_if.wready;
  assign ob_ov[1] = m_if.wvalid;
  assign ob_od[1] = {27'd0, m_if.wdata, m_if.wstrb, m_if.wlast};

  assign s_if.arvalid = drv_v[2];
  assign {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst} = drv_d[2][32:0];
  assign m_if.arready = drv_r[2];
  assign ob_ir[2] = s_if.arready;
  assign ob_ov[2] = m_if.arvalid;
  assign ob_od[2] = {31'd0, m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst};

  assign m_if.bvalid = drv_v[3];
  assign m_if.bid = drv_d[3][3:0];
  assign s_if.bready = drv_r[3];
  assign ob_ir[3] = m_if.bready;
  assign ob_ov[3] = s_if.bvalid;
  assign ob_od[3] = {60'd0, s_if.bid};

  assign m_if.rvalid = drv_v[4];
  assign {m_if.rid, m_if.rdata, m_if.rlast} = drv_d[4][36:0];
  assign s_if.rready = drv_r[4];
  assign ob_ir[4] = m_if.rready;
  assign ob_ov[4] = s_if.rvalid;
  assign ob_od[4] = {27'd0, s_if.rid, s_if.rdata, s_if.rlast};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd(input int c);
    logic [63:0] m;
    m = (64'd1 << wid[c]) - 64'd1;
    return {$urandom, $urandom} & m;
  endfunction

  function automatic bit busy();
    for (int c = 0; c < 5; c++)
      if (src[c].size() != 0 || mq[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clr_cnt();
    for (int c = 0; c < 5; c++) begin
      nout[c] = 0; nlast[c] = 0;
      first_in[c] = -1; first_out[c] = -1; last_out[c] = -1;
    end
  endtask

  // one clock: drive at negedge, compare against the queue model, update model at posedge
  task automatic step();
    logic ih [5];
    logic oh [5];
    int sz;
    for (int c = 0; c < 5; c++) begin
      drv_v[c] = (src[c].size() != 0) && (($urandom % 100) < vp[c]);
      drv_d[c] = drv_v[c] ? src[c][0] : rnd(c);
      drv_r[c] = ($urandom % 100) < rp[c];
    end
    for (int c = 0; c < 5; c++) begin
      sz = mq[c].size();
      chk({cn[c], "_in_ready"}, 64'(ob_ir[c]), 64'(sz < 2));
      chk({cn[c], "_out_valid"}, 64'(ob_ov[c]), 64'(sz > 0));
      if (sz > 0) chk({cn[c], "_out_data"}, ob_od[c], mq[c][0]);
      ih[c] = drv_v[c] && (sz < 2) && rst_n;
      oh[c] = drv_r[c] && (sz > 0) && rst_n;
    end
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      if (!rst_n) begin
        mq[c].delete();
      end else begin
        if (oh[c]) begin
          if ((c == 1 || c == 4) && mq[c][0][0]) nlast[c]++;
          void'(mq[c].pop_front());
          nout[c]++;
          if (first_out[c] < 0) first_out[c] = cyc;
          last_out[c] = cyc;
        end
        if (ih[c]) begin
          mq[c].push_back(src[c].pop_front());
          if (first_in[c] < 0) first_in[c] = cyc;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int maxc, input string tag);
    int n = 0;
    while (busy() && n < maxc) begin
      step();
      n++;
    end
    chk({tag, "_drain_timeout"}, 64'(busy()), 64'd0);
  endtask

  initial begin
    logic [3:0]  arid;
    logic [63:0] beat;
    for (int c = 0; c < 5; c++) begin
      drv_v[c] = 1'b0; drv_r[c] = 1'b1; drv_d[c] = '0;
      vp[c] = 100; rp[c] = 100;
    end
    clr_cnt();
    #1 rst_n = 1'b0;
    @(negedge clk);

    // reset with AWVALID held high: nothing moves, all ready
    src[0].push_back(rnd(0));
    run(3);
    chk("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
    chk("rst_s_awready", 64'(s_if.awready), 64'd1);
    src[0].delete();
    rst_n = 1'b1;
    run(4);
    chk("rst_no_spurious", 64'(nout[0] + nout[1] + nout[2] + nout[3] + nout[4]), 64'd0);

    // 16-beat INCR write streaming with the RAM always ready
    clr_cnt();
    src[0].push_back({31'd0, 4'h3, 16'h0010, 8'd15, 3'd2, 2'b01});
    for (int i = 0; i < 16; i++) begin
      beat = {27'd0, 32'(i), 4'hF, 1'(i == 15)};
      src[1].push_back(beat);
    end
    drain(100, "stream");
    src[3].push_back(64'h3);
    drain(20, "stream_b");
    chk("stream_w_beats", 64'(nout[1]), 64'd16);
    chk("stream_wlast_cnt", 64'(nlast[1]), 64'd1);
    chk("stream_w_span", 64'(last_out[1] - first_out[1]), 64'd15);
    chk("stream_w_latency", 64'(first_out[1] - first_in[1]), 64'd1);
    chk("stream_aw_cnt", 64'(nout[0]), 64'd1);
    chk("stream_b_cnt", 64'(nout[3]), 64'd1);

    // write data backpressure: RAM WREADY low for 5 cycles mid-burst
    clr_cnt();
    for (int i = 0; i < 16; i++) begin
      beat = {27'd0, 32'h100 + 32'(i), 4'($urandom), 1'(i == 15)};
      src[1].push_back(beat);
    end
    run(4);
    rp[1] = 0;
    run(2);
    chk("bp_wready_low", 64'(s_if.wready), 64'd0);
    run(3);
    chk("bp_buffered_beats", 64'(nout[1] + 2), 64'(16 - src[1].size()));
    rp[1] = 100;
    drain(100, "bp");
    chk("bp_w_beats", 64'(nout[1]), 64'd16);

    // 256-beat read with random RREADY
    clr_cnt();
    arid = 4'($urandom);
    src[2].push_back({31'd0, arid, 16'h0200, 8'd255, 3'd2, 2'b01});
    drain(20, "rd_ar");
    for (int i = 0; i < 256; i++) begin
      beat = {27'd0, arid, $urandom, 1'(i == 255)};
      src[4].push_back(beat);
    end
    vp[4] = 80; rp[4] = 50;
    drain(3000, "rd");
    chk("rd_r_beats", 64'(nout[4]), 64'd256);
    chk("rd_rlast_cnt", 64'(nlast[4]), 64'd1);
    vp[4] = 100; rp[4] = 100;

    // all five channels at once: full rate first, then random valid/ready
    clr_cnt();
    for (int c = 0; c < 5; c++)
      for (int i = 0; i < 40; i++) src[c].push_back(rnd(c));
    run(20);
    for (int c = 0; c < 5; c++) chk({"simul_rate_", cn[c]}, 64'(nout[c]), 64'd19);
    for (int c = 0; c < 5; c++) begin vp[c] = 60; rp[c] = 60; end
    drain(2000, "simul");
    for (int c = 0; c < 5; c++) chk({"simul_total_", cn[c]}, 64'(nout[c]), 64'd40);
    for (int c = 0; c < 5; c++) begin vp[c] = 100; rp[c] = 100; end

    // reset mid-burst with the W skid entry occupied
    clr_cnt();
    for (int i = 0; i < 16; i++) begin
      beat = {27'd0, 32'h200 + 32'(i), 4'hF, 1'(i == 15)};
      src[1].push_back(beat);
    end
    run(6);
    rp[1] = 0;
    run(3);
    chk("mid_skid_full", 64'(s_if.wready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk({"mid_rst_valid_", cn[c]}, 64'(ob_ov[c]), 64'd0);
      chk({"mid_rst_ready_", cn[c]}, 64'(ob_ir[c]), 64'd1);
    end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      src[c].delete();
      mq[c].delete();
    end
    rp[1] = 100;
    run(2);
    rst_n = 1'b1;
    clr_cnt();
    run(4);
    chk("mid_rst_no_replay", 64'(nout[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
